// File: rtl/tia_horizontal_timing_gen.sv
// tia_horizontal_timing_gen: binary line counter with hsync, colour burst, hblank, composite blank/sync, HMOVE late blank and multi-line WSYNC wait
//   clk        colour clock, rising edge
//   r_bar      asynchronous active-low reset
//   wsyn       WSYNC strobe; wsyn_lines = extra whole lines to hold rdy low
//   hmove      HMOVE strobe (used only with TIA_HTIMING_LATE_HBLANK_EN defined)
//   vsyn/vblk  vertical sync/blank levels
//   hcount, line_start, hsync, cb, hblank, blank, syn, motck, late, rdy
//   Macro TIA_HTIMING_LATE_HBLANK_EN enables the 8-clock HMOVE blank extension.
module tia_horizontal_timing_gen #(
  parameter int LINE_CLKS   = 228,
  parameter int CNT_W       = 8,
  parameter int HSYNC_START = 20,
  parameter int HSYNC_END   = 36,
  parameter int CB_START    = 40,
  parameter int CB_END      = 56,
  parameter int HBLANK_END  = 68,
  parameter int WAIT_W      = 2
) (
  input  logic              clk,
  input  logic              r_bar,
  input  logic              wsyn,
  input  logic [WAIT_W-1:0] wsyn_lines,
  input  logic              hmove,
  input  logic              vsyn,
  input  logic              vblk,
  output logic [CNT_W-1:0]  hcount,
  output logic              line_start,
  output logic              hsync,
  output logic              cb,
  output logic              hblank,
  output logic              blank,
  output logic              syn,
  output logic              motck,
  output logic              late,
  output logic              rdy
);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(LINE_CLKS - 1);
  localparam logic [CNT_W-1:0] HS_S    = CNT_W'(HSYNC_START);
  localparam logic [CNT_W-1:0] HS_E    = CNT_W'(HSYNC_END);
  localparam logic [CNT_W-1:0] CB_S    = CNT_W'(CB_START);
  localparam logic [CNT_W-1:0] CB_E    = CNT_W'(CB_END);
  localparam logic [CNT_W-1:0] HB_E    = CNT_W'(HBLANK_END);
  localparam logic [CNT_W-1:0] HB_LATE = CNT_W'(HBLANK_END + 8);
  logic [CNT_W-1:0]  hcount_q, hcount_d;
  logic              rdy_q, rdy_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              wrap;
  // a wsyn strobe always wins over the wrap-time release/decrement
  always_comb begin
    wrap       = hcount_q == LAST;
    hcount_d   = wrap ? '0 : hcount_q + 1'b1;
    rdy_d      = wsyn ? 1'b0 : (wrap && !rdy_q && wait_cnt_q == '0) ? 1'b1 : rdy_q;
    wait_cnt_d = wsyn ? wsyn_lines : (wrap && !rdy_q && wait_cnt_q != '0) ? wait_cnt_q - 1'b1 : wait_cnt_q;
  end
  always_ff @(posedge clk or negedge r_bar) begin
    if (!r_bar) begin
      hcount_q   <= '0;
      rdy_q      <= 1'b1;
      wait_cnt_q <= '0;
    end else begin
      hcount_q   <= hcount_d;
      rdy_q      <= rdy_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end
`ifdef TIA_HTIMING_LATE_HBLANK_EN
  logic late_q, late_d, hmove_pend_q, hmove_pend_d;
  // a strobe on the wrap cycle is queued for the line after the one being entered
  always_comb begin
    late_d       = wrap ? hmove_pend_q : late_q;
    hmove_pend_d = wrap ? hmove : hmove_pend_q | hmove;
  end
  always_ff @(posedge clk or negedge r_bar) begin
    if (!r_bar) begin
      late_q       <= 1'b0;
      hmove_pend_q <= 1'b0;
    end else begin
      late_q       <= late_d;
      hmove_pend_q <= hmove_pend_d;
    end
  end
  assign late = late_q;
`else
  logic unused_hmove;
  assign unused_hmove = hmove;
  assign late         = 1'b0;
`endif
  assign hcount     = hcount_q;
  assign line_start = hcount_q == '0;
  assign hsync      = hcount_q >= HS_S && hcount_q < HS_E;
  assign cb         = hcount_q >= CB_S && hcount_q < CB_E;
  assign hblank     = hcount_q < (late ? HB_LATE : HB_E);
  assign blank      = hblank | vblk;
  assign syn        = hsync ^ vsyn;
  assign motck      = ~hblank;
  assign rdy        = rdy_q;
endmodule
